hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV64I+Zba core. It keeps its own shadow copy of the register-destination and valid state for the EX, MEM and WB stages, and from that state it drives the EX-stage operand forwarding selects. It also generates the stall and flush strobes that sequence the IF/ID and ID/EX pipeline registers around the execute stage: a one-cycle stall for load-use, and a flush on a taken branch or jump. Saturating event counters expose stall and flush activity for performance debug.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package hazard_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Destination/valid shadow of one pipeline stage.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             load;
   } stage_info_t;

   // M and W only act as forwarding sources, so they drop the load flag.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
   } fwd_src_t;

   // A stage can supply a value when it holds a real writer of a non-zero rd
   // that matches the source register.
   function automatic logic src_hit(input fwd_src_t src, input logic [REG_W-1:0] rs);
      return src.valid && src.regwrite && (src.rd != '0) && (src.rd == rs);
   endfunction

   // MEM holds the younger result, so it is checked last and wins.
   function automatic fwd_sel_e fwd_select(input fwd_src_t m, input fwd_src_t w,
                                           input logic [REG_W-1:0] rs);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (src_hit(w, rs)) sel = FWD_WB;
      if (src_hit(m, rs)) sel = FWD_MEM;
      return sel;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; en is sampled every cycle.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   en         : count this cycle
//   count      : current value
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX forwarding selects, load-use stall and redirect flush strobes.
// Latency: strobes and selects are combinational (same cycle); counters update next edge.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and bubbles ID/EX.
//   clk, rst_n                : clock, asynchronous active-low reset
//   Rs1_D, Rs2_D, Rd_D        : register fields of the instruction in ID
//   RegWrite_D, Load_D        : ID instruction writes rd / is a load
//   PCSrc_E                   : taken branch or jump from EX
//   ForwardA_E, ForwardB_E    : EX operand selects (00 RF, 01 WB, 10 MEM)
//   Stall_F, Stall_D          : hold PC and IF/ID
//   Flush_D, Flush_E          : bubble IF/ID and ID/EX
//   StallCount, FlushCount    : saturating stall-cycle and redirect counters
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rd_D,
   input  logic             RegWrite_D,
   input  logic             Load_D,
   input  logic             PCSrc_E,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic             Stall_F,
   output logic             Stall_D,
   output logic             Flush_D,
   output logic             Flush_E,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // Shadow of the real pipeline registers; only correct if the datapath
   // honours the strobes driven below.
   logic             valid_d;
   stage_info_t      st_e;
   logic [REG_W-1:0] rs1_e;
   logic [REG_W-1:0] rs2_e;
   fwd_src_t         st_m;
   fwd_src_t         st_w;

   logic     redirect;
   logic     load_use;
   logic     stall;
   fwd_sel_e fwd_a;
   fwd_sel_e fwd_b;

   // PCSrc_E passes one AND here and one OR into Flush_E; keep it that shallow.
   assign redirect = PCSrc_E & st_e.valid;

   // Conservative: both source fields are compared whatever the format.
   assign load_use = valid_d & st_e.valid & st_e.load & (st_e.rd != '0) &
                     ((st_e.rd == Rs1_D) | (st_e.rd == Rs2_D));

   // A redirect squashes the consumer, so stalling for it would be pointless.
   assign stall   = load_use & ~redirect;
   assign Stall_F = stall;
   assign Stall_D = stall;
   assign Flush_D = redirect;
   assign Flush_E = redirect | load_use;

   assign fwd_a      = fwd_select(st_m, st_w, rs1_e);
   assign fwd_b      = fwd_select(st_m, st_w, rs2_e);
   assign ForwardA_E = fwd_a;
   assign ForwardB_E = fwd_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_d <= 1'b0;
         st_e    <= '0;
         rs1_e   <= '0;
         rs2_e   <= '0;
         st_m    <= '0;
         st_w    <= '0;
      end else begin
         if (Flush_D) begin
            valid_d <= 1'b0;
         end else if (!stall) begin
            valid_d <= 1'b1;
         end

         // Fields of a flushed slot are don't-care; clearing them keeps
         // a bubble's stale indices out of the forwarding compare.
         if (Flush_E) begin
            st_e  <= '0;
            rs1_e <= '0;
            rs2_e <= '0;
         end else begin
            st_e.valid    <= valid_d;
            st_e.rd       <= Rd_D;
            st_e.regwrite <= RegWrite_D;
            st_e.load     <= Load_D;
            rs1_e         <= Rs1_D;
            rs2_e         <= Rs2_D;
         end

         // MEM and WB never stall.
         st_m.valid    <= st_e.valid;
         st_m.rd       <= st_e.rd;
         st_m.regwrite <= st_e.regwrite;
         st_w          <= st_m;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stall),
      .count (StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (redirect),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, random run against a model, reset corners.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns before the rising edge.
// Backpressure: the D-stage instruction is held while the reference model says stall.
module tb_hazard_ctrl;

   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4:0]    Rs1_D = '0, Rs2_D = '0, Rd_D = '0;
   logic          RegWrite_D = 1'b0, Load_D = 1'b0, PCSrc_E = 1'b0;
   logic [1:0]    ForwardA_E, ForwardB_E;
   logic          Stall_F, Stall_D, Flush_D, Flush_E;
   logic [CW-1:0] StallCount, FlushCount;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Rs1_D      (Rs1_D),
      .Rs2_D      (Rs2_D),
      .Rd_D       (Rd_D),
      .RegWrite_D (RegWrite_D),
      .Load_D     (Load_D),
      .PCSrc_E    (PCSrc_E),
      .ForwardA_E (ForwardA_E),
      .ForwardB_E (ForwardB_E),
      .Stall_F    (Stall_F),
      .Stall_D    (Stall_D),
      .Flush_D    (Flush_D),
      .Flush_E    (Flush_E),
      .StallCount (StallCount),
      .FlushCount (FlushCount)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fwdA"}, int'(ForwardA_E), 0);
      chk({tag, "_fwdB"}, int'(ForwardB_E), 0);
      chk({tag, "_stallF"}, int'(Stall_F), 0);
      chk({tag, "_stallD"}, int'(Stall_D), 0);
      chk({tag, "_flushD"}, int'(Flush_D), 0);
      chk({tag, "_flushE"}, int'(Flush_E), 0);
      chk({tag, "_scnt"}, int'(StallCount), 0);
      chk({tag, "_fcnt"}, int'(FlushCount), 0);
   endtask

   // ---------------- reference model ----------------
   // An instruction record travels through slots 1..3 (E, M, W).
   typedef struct {
      bit v;
      int rs1, rs2, rd;
      bit rw, ld;
   } ins_t;

   ins_t pipe [1:3];
   bit   vd;
   int   sc, fc;

   function automatic ins_t empty_ins();
      ins_t r;
      r.v = 0; r.rs1 = 0; r.rs2 = 0; r.rd = 0; r.rw = 0; r.ld = 0;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 1; i <= 3; i++) pipe[i] = empty_ins();
      vd = 0; sc = 0; fc = 0;
   endtask

   // Youngest producer (M before W) of a non-zero register wins.
   function automatic int ref_fwd(input int rs);
      if (rs == 0) return 0;
      for (int s = 2; s <= 3; s++)
         if (pipe[s].v && pipe[s].rw && pipe[s].rd == rs) return (s == 2) ? 2 : 1;
      return 0;
   endfunction

   task automatic run_cycle(input ins_t d, input bit pc, output bit stalled);
      bit redir, lu, st, fe;
      @(negedge clk);
      Rs1_D = 5'(d.rs1); Rs2_D = 5'(d.rs2); Rd_D = 5'(d.rd);
      RegWrite_D = d.rw; Load_D = d.ld; PCSrc_E = pc;
      #4;
      redir = pc && pipe[1].v;
      lu = vd && pipe[1].v && pipe[1].ld && pipe[1].rd != 0 &&
           (pipe[1].rd == d.rs1 || pipe[1].rd == d.rs2);
      st = lu && !redir;
      fe = redir || lu;
      // Fields of an empty E slot may be stale after a flush; only a real
      // instruction in E has defined operand selects.
      if (pipe[1].v) begin
         chk("m_fwdA", int'(ForwardA_E), ref_fwd(pipe[1].rs1));
         chk("m_fwdB", int'(ForwardB_E), ref_fwd(pipe[1].rs2));
      end
      chk("m_stallF", int'(Stall_F), int'(st));
      chk("m_stallD", int'(Stall_D), int'(st));
      chk("m_flushD", int'(Flush_D), int'(redir));
      chk("m_flushE", int'(Flush_E), int'(fe));
      chk("m_scnt", int'(StallCount), sc);
      chk("m_fcnt", int'(FlushCount), fc);
      @(posedge clk);
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      if (fe) pipe[1] = empty_ins();
      else begin
         pipe[1] = d;
         pipe[1].v = vd;
      end
      if (redir) vd = 0;
      else if (!st) vd = 1;
      if (st && sc < CMAX) sc++;
      if (redir && fc < CMAX) fc++;
      stalled = st;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   function automatic ins_t mk(input int rs1, rs2, rd, input bit rw, ld);
      ins_t r;
      r.v = 1; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.ld = ld;
      return r;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld, pc;
      logic [1:0] fa, fb;
      logic       fchk, stall, fd, fe;
      int         sc, fc;
   } vec_t;

   function automatic vec_t v(input int rs1, rs2, rd, rw, ld, pc, fa, fb, fchk,
                              stall, fd, fe, sc, fc);
      vec_t r;
      r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
      r.rw = 1'(rw); r.ld = 1'(ld); r.pc = 1'(pc);
      r.fa = 2'(fa); r.fb = 2'(fb); r.fchk = 1'(fchk);
      r.stall = 1'(stall); r.fd = 1'(fd); r.fe = 1'(fe);
      r.sc = sc; r.fc = fc;
      return r;
   endfunction

   vec_t tab [16];

   initial begin
      bit   stl;
      ins_t d;
      bit   pc;

      //            rs1 rs2 rd rw ld pc  fa fb chk  st fd fe  sc fc
      tab[0]  = v(  0,  0,  0, 0, 0, 0,  0, 0, 1,   0, 0, 0,  0, 0); // D invalid after reset
      tab[1]  = v(  1,  2,  5, 1, 0, 0,  0, 0, 1,   0, 0, 0,  0, 0); // add x5
      tab[2]  = v(  5,  5,  6, 1, 0, 0,  0, 0, 1,   0, 0, 0,  0, 0); // add x6,x5,x5
      tab[3]  = v(  1,  2,  8, 1, 0, 0,  2, 2, 1,   0, 0, 0,  0, 0); // x6 in E: MEM fwd
      tab[4]  = v(  6,  1, 10, 1, 0, 0,  0, 0, 1,   0, 0, 0,  0, 0); // x10 uses x6 one gap later
      tab[5]  = v(  1,  0,  7, 1, 1, 0,  1, 0, 1,   0, 0, 0,  0, 0); // ld x7; x10 in E: WB fwd
      tab[6]  = v(  7,  3, 11, 1, 0, 0,  0, 0, 1,   1, 0, 1,  0, 0); // load-use stall
      tab[7]  = v(  7,  3, 11, 1, 0, 0,  0, 0, 0,   0, 0, 0,  1, 0); // held, bubble in E
      tab[8]  = v(  1,  2,  0, 1, 0, 0,  1, 0, 1,   0, 0, 0,  1, 0); // consumer gets WB
      tab[9]  = v(  0,  0, 12, 1, 0, 0,  0, 0, 1,   0, 0, 0,  1, 0);
      tab[10] = v(  1,  0,  0, 1, 1, 0,  0, 0, 1,   0, 0, 0,  1, 0); // x0 never forwarded
      tab[11] = v(  0,  1, 13, 1, 0, 0,  0, 0, 1,   0, 0, 0,  1, 0); // ld x0: no stall
      tab[12] = v(  2,  0, 14, 1, 1, 0,  0, 0, 1,   0, 0, 0,  1, 0); // ld x14
      tab[13] = v( 14,  1, 15, 1, 0, 1,  0, 0, 1,   0, 1, 1,  1, 0); // redirect beats load-use
      tab[14] = v(  3,  4, 16, 1, 0, 1,  0, 0, 0,   0, 0, 0,  1, 1); // bubble cannot redirect
      tab[15] = v(  3,  4, 16, 1, 0, 1,  0, 0, 1,   0, 0, 0,  1, 1); // E bubble again

      model_reset();
      #3;
      chk_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         Rs1_D = tab[i].rs1; Rs2_D = tab[i].rs2; Rd_D = tab[i].rd;
         RegWrite_D = tab[i].rw; Load_D = tab[i].ld; PCSrc_E = tab[i].pc;
         #4;
         if (tab[i].fchk) begin
            chk($sformatf("v%0d_fwdA", i), int'(ForwardA_E), int'(tab[i].fa));
            chk($sformatf("v%0d_fwdB", i), int'(ForwardB_E), int'(tab[i].fb));
         end
         chk($sformatf("v%0d_stallF", i), int'(Stall_F), int'(tab[i].stall));
         chk($sformatf("v%0d_stallD", i), int'(Stall_D), int'(tab[i].stall));
         chk($sformatf("v%0d_flushD", i), int'(Flush_D), int'(tab[i].fd));
         chk($sformatf("v%0d_flushE", i), int'(Flush_E), int'(tab[i].fe));
         chk($sformatf("v%0d_scnt", i), int'(StallCount), tab[i].sc);
         chk($sformatf("v%0d_fcnt", i), int'(FlushCount), tab[i].fc);
      end

      // ---------------- random run against the model ----------------
      do_reset();
      stl = 0;
      d = empty_ins();
      for (int n = 0; n < 600; n++) begin
         // A stalled IF/ID keeps presenting the same instruction.
         if (!stl) begin
            d = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
         end
         pc = ($urandom_range(0, 3) == 0);
         run_cycle(d, pc, stl);
      end
      // Many stalls and redirects have occurred with a 3-bit counter.
      @(negedge clk);
      chk("stall_sat", int'(StallCount), CMAX);
      chk("flush_sat", int'(FlushCount), CMAX);

      // ---------------- async reset in the middle of a stall ----------------
      do_reset();
      run_cycle(mk(0, 0, 0, 0, 0), 0, stl);
      run_cycle(mk(1, 0, 7, 1, 1), 0, stl);          // ld x7
      @(negedge clk);
      Rs1_D = 5'd7; Rs2_D = 5'd3; Rd_D = 5'd11; RegWrite_D = 1'b1; Load_D = 1'b0; PCSrc_E = 1'b1;
      #2;
      chk("pre_rst_flushE", int'(Flush_E), 1);
      chk("pre_rst_flushD", int'(Flush_D), 1);
      PCSrc_E = 1'b0;
      #1;
      chk("pre_rst_stall", int'(Stall_D), 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      // Stale ld x7 / x11 must not leak into forwarding after reset.
      run_cycle(mk(7, 7, 8, 1, 0), 0, stl);
      run_cycle(mk(7, 8, 9, 1, 0), 0, stl);
      run_cycle(mk(11, 7, 10, 1, 0), 0, stl);
      run_cycle(mk(9, 8, 12, 1, 0), 0, stl);
      run_cycle(mk(1, 2, 13, 1, 0), 0, stl);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
